// File: rtl/reg_alu_seq.sv
// -----------------------------------------------------------------------------
// reg_alu_seq
//
// Instruction sequencer for the reg_alu register-file/ALU datapath. It takes
// 16-bit instruction words over a valid/ready stream and turns each one into
// per-cycle reg_alu control. It also keeps a sticky carry flag and returns
// read-back data over a valid/ready result port.
//
// Instruction encoding (instr[15:14]):
//   00 NOP : no effect
//   01 LDI : rd = [10:8]; the next accepted word is the 16-bit immediate
//   10 ALU : op = [13:11], rd = [10:8], ra = [7:5], rb = [4:2]
//   11 RD  : ra = [7:5]; the register value is returned on res_data
//
// Ports:
//   clk            in   rising-edge clock
//   reset          in   synchronous, active-high reset (also resets reg_alu)
//   instr_valid    in   instruction word present
//   instr_ready    out  sequencer accepts a word this cycle
//   instr[15:0]    in   instruction word
//   res_valid      out  read-back data available
//   res_ready      in   consumer takes the result
//   res_data[15:0] out  read-back register value
//   carry          out  carry flag from the last ALU instruction
//   busy           out  sequencer is not in IDLE
//   alu_sel        out  reg_alu.sel  (0 = d_in, 1 = ALU result)
//   alu_wr         out  reg_alu.wr
//   alu_op[2:0]    out  reg_alu.op (passed through uninterpreted)
//   alu_rd_addr_a  out  reg_alu read port A address
//   alu_rd_addr_b  out  reg_alu read port B address
//   alu_wr_addr    out  reg_alu write address
//   alu_d_in[15:0] out  reg_alu.d_in
//   alu_d_out_a    in   reg_alu read port A data
//   alu_cout       in   reg_alu.cout (registered inside reg_alu)
// -----------------------------------------------------------------------------
module reg_alu_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [15:0] instr,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [15:0] res_data,
    output logic        carry,
    output logic        busy,
    output logic        alu_sel,
    output logic        alu_wr,
    output logic [2:0]  alu_op,
    output logic [2:0]  alu_rd_addr_a,
    output logic [2:0]  alu_rd_addr_b,
    output logic [2:0]  alu_wr_addr,
    output logic [15:0] alu_d_in,
    input  logic [15:0] alu_d_out_a,
    input  logic        alu_cout
);

    // Sequencer states
    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_IMM   = 3'd1;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_CFLAG = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;
    localparam logic [2:0] ST_RESP  = 3'd5;

    // Instruction classes in instr[15:14]
    localparam logic [1:0] OPC_NOP = 2'b00;
    localparam logic [1:0] OPC_LDI = 2'b01;
    localparam logic [1:0] OPC_ALU = 2'b10;
    localparam logic [1:0] OPC_RD  = 2'b11;

    logic [2:0]  state;
    logic [2:0]  state_next;

    // Fields latched from the instruction header
    logic        exec_is_alu;   // EXEC issues an ALU write (1) or an LDI write (0)
    logic [2:0]  op_q;
    logic [2:0]  rd_q;
    logic [2:0]  ra_q;
    logic [2:0]  rb_q;
    logic [15:0] imm_q;

    logic        accept;
    logic        res_taken;

    // Field slices of the incoming word
    logic [1:0]  f_class;
    logic [2:0]  f_op;
    logic [2:0]  f_rd;
    logic [2:0]  f_ra;
    logic [2:0]  f_rb;

    assign f_class = instr[15:14];
    assign f_op    = instr[13:11];
    assign f_rd    = instr[10:8];
    assign f_ra    = instr[7:5];
    assign f_rb    = instr[4:2];

    // instr[1:0] carries no information in any instruction class.
    logic unused_instr_bits;
    assign unused_instr_bits = &{1'b0, instr[1:0]};

    // -------------------------------------------------------------------------
    // Handshakes. reset -> instr_ready is the only combinational path: the
    // source must never see a word taken in a cycle whose edge discards it.
    // -------------------------------------------------------------------------
    assign instr_ready = !reset && ((state == ST_IDLE) || (state == ST_IMM));
    assign accept      = instr_valid && instr_ready;
    assign res_valid   = (state == ST_RESP);
    assign res_taken   = res_valid && res_ready;
    assign busy        = (state != ST_IDLE);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every signal assigned in an always_comb gets a default at the top
    // of the block, so no path can leave it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    case (f_class)
                        OPC_LDI: state_next = ST_IMM;
                        OPC_ALU: state_next = ST_EXEC;
                        OPC_RD:  state_next = ST_READ;
                        default: state_next = ST_IDLE;
                    endcase
                end
            end
            ST_IMM:   if (accept) state_next = ST_EXEC;
            ST_EXEC:  state_next = exec_is_alu ? ST_CFLAG : ST_IDLE;
            ST_CFLAG: state_next = ST_IDLE;
            ST_READ:  state_next = ST_RESP;
            ST_RESP:  if (res_taken) state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State, latched fields, carry flag and result register
    // -------------------------------------------------------------------------
    // NOTE: sequential state is assigned with non-blocking (<=) so every
    // register samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            exec_is_alu <= 1'b0;
            op_q        <= '0;
            rd_q        <= '0;
            ra_q        <= '0;
            rb_q        <= '0;
            imm_q       <= '0;
            carry       <= 1'b0;
            res_data    <= '0;
        end else begin
            state <= state_next;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        case (f_class)
                            OPC_LDI: begin
                                exec_is_alu <= 1'b0;
                                rd_q        <= f_rd;
                            end
                            OPC_ALU: begin
                                exec_is_alu <= 1'b1;
                                op_q        <= f_op;
                                rd_q        <= f_rd;
                                ra_q        <= f_ra;
                                rb_q        <= f_rb;
                            end
                            OPC_RD: begin
                                ra_q <= f_ra;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_IMM: begin
                    if (accept) begin
                        imm_q <= instr;
                    end
                end
                // reg_alu registers its carry at the EXEC write edge, so it
                // is valid to sample throughout CFLAG.
                ST_CFLAG: carry    <= alu_cout;
                // Read port A is combinational in reg_alu; the addressed
                // value is stable for the whole READ cycle.
                ST_READ:  res_data <= alu_d_out_a;
                default: ;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // reg_alu control: pure decodes of registered state. Everything is zero
    // outside EXEC and READ, so nothing stray reaches the datapath.
    // -------------------------------------------------------------------------
    always_comb begin
        alu_sel       = 1'b0;
        alu_wr        = 1'b0;
        alu_op        = '0;
        alu_rd_addr_a = '0;
        alu_rd_addr_b = '0;
        alu_wr_addr   = '0;
        alu_d_in      = '0;
        case (state)
            ST_EXEC: begin
                alu_wr      = 1'b1;
                alu_wr_addr = rd_q;
                if (exec_is_alu) begin
                    alu_sel       = 1'b1;
                    alu_op        = op_q;
                    alu_rd_addr_a = ra_q;
                    alu_rd_addr_b = rb_q;
                end else begin
                    alu_d_in = imm_q;
                end
            end
            ST_READ: begin
                alu_rd_addr_a = ra_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_reg_alu_seq.sv
// -----------------------------------------------------------------------------
// tb_reg_alu_seq
//
// Directed testbench for reg_alu_seq. A small behavioural reg_alu (8 x 16-bit
// registers, r0 hard-wired to zero, registered carry) sits on the datapath
// side. Inputs are driven and outputs are sampled on the falling clock edge.
// Model ALU ops: 0/5 add, 1 sub, 2 and, 3 or, 4 xor, 6/7 pass A.
// -----------------------------------------------------------------------------
module tb_reg_alu_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic        res_valid;
    logic        res_ready;
    logic [15:0] res_data;
    logic        carry;
    logic        busy;
    logic        alu_sel;
    logic        alu_wr;
    logic [2:0]  alu_op;
    logic [2:0]  alu_rd_addr_a;
    logic [2:0]  alu_rd_addr_b;
    logic [2:0]  alu_wr_addr;
    logic [15:0] alu_d_in;
    logic [15:0] alu_d_out_a;
    logic        alu_cout;

    int vectors    = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    reg_alu_seq dut (
        .clk           (clk),
        .reset         (reset),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .instr         (instr),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .carry         (carry),
        .busy          (busy),
        .alu_sel       (alu_sel),
        .alu_wr        (alu_wr),
        .alu_op        (alu_op),
        .alu_rd_addr_a (alu_rd_addr_a),
        .alu_rd_addr_b (alu_rd_addr_b),
        .alu_wr_addr   (alu_wr_addr),
        .alu_d_in      (alu_d_in),
        .alu_d_out_a   (alu_d_out_a),
        .alu_cout      (alu_cout)
    );

    // ---------------- behavioural reg_alu ----------------
    logic [15:0] regs [8];
    logic [15:0] m_a, m_b, m_res;
    logic        m_c;

    assign m_a         = regs[alu_rd_addr_a];
    assign m_b         = regs[alu_rd_addr_b];
    assign alu_d_out_a = m_a;

    always_comb begin
        m_c   = 1'b0;
        m_res = m_a;
        case (alu_op)
            3'd0, 3'd5: {m_c, m_res} = {1'b0, m_a} + {1'b0, m_b};
            3'd1:       {m_c, m_res} = {1'b0, m_a} - {1'b0, m_b};
            3'd2:       m_res = m_a & m_b;
            3'd3:       m_res = m_a | m_b;
            3'd4:       m_res = m_a ^ m_b;
            default:    m_res = m_a;
        endcase
    end

    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 8; i++) regs[i] <= '0;
            alu_cout <= 1'b0;
        end else if (alu_wr) begin
            if (alu_wr_addr != 3'd0) regs[alu_wr_addr] <= alu_sel ? m_res : alu_d_in;
            if (alu_sel) alu_cout <= m_c;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a falling edge; returns at the falling edge right after the
    // word was accepted.
    task automatic send_word(input logic [15:0] w, input string name);
        int k = 0;
        instr_valid = 1'b1;
        instr       = w;
        while (!instr_ready && k < 20) begin
            @(negedge clk);
            k++;
        end
        vectors++;
        if (instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s accept: instr_ready=%b required 1 (timeout)", name, instr_ready);
        end
        @(negedge clk);
        instr_valid = 1'b0;
        instr       = 16'h0000;
    endtask

    task automatic do_ldi(input logic [2:0] rd, input logic [15:0] imm, input string name);
        send_word({2'b01, 3'b000, rd, 8'h00}, name);
        vectors++;
        if (instr_ready !== 1'b1 || alu_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL %s imm_wait: ready=%b wr=%b required ready=1 wr=0", name, instr_ready, alu_wr);
        end
        send_word(imm, name);
        vectors++;
        if (alu_wr !== 1'b1 || alu_sel !== 1'b0 || alu_wr_addr !== rd || alu_d_in !== imm) begin
            miscompares++;
            $display("FAIL %s exec: wr=%b sel=%b addr=%0d d_in=%h required wr=1 sel=0 addr=%0d d_in=%h",
                     name, alu_wr, alu_sel, alu_wr_addr, alu_d_in, rd, imm);
        end
        @(negedge clk);
        vectors++;
        if (alu_wr !== 1'b0 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s done: wr=%b ready=%b required wr=0 ready=1", name, alu_wr, instr_ready);
        end
    endtask

    task automatic do_read(input logic [2:0] ra, input logic [15:0] exp, input string name);
        send_word({2'b11, 3'b000, 3'b000, ra, 5'b00000}, name);
        vectors++;
        if (res_valid !== 1'b0 || alu_rd_addr_a !== ra || alu_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL %s read: res_valid=%b rd_addr_a=%0d wr=%b required 0/%0d/0",
                     name, res_valid, alu_rd_addr_a, alu_wr, ra);
        end
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== exp) begin
            miscompares++;
            $display("FAIL %s resp: res_valid=%b res_data=%h required 1/%h", name, res_valid, res_data, exp);
        end
        res_ready = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || instr_ready !== 1'b1 || res_data !== exp) begin
            miscompares++;
            $display("FAIL %s after: res_valid=%b ready=%b res_data=%h required 0/1/%h",
                     name, res_valid, instr_ready, res_data, exp);
        end
    endtask

    task automatic do_alu(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra,
                          input logic [2:0] rb, input logic exp_carry, input string name);
        send_word({2'b10, op, rd, ra, rb, 2'b00}, name);
        vectors++;
        if (alu_wr !== 1'b1 || alu_sel !== 1'b1 || alu_op !== op || alu_wr_addr !== rd ||
            alu_rd_addr_a !== ra || alu_rd_addr_b !== rb || instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL %s exec: wr=%b sel=%b op=%0d wa=%0d ra=%0d rb=%0d ready=%b required 1/1/%0d/%0d/%0d/%0d/0",
                     name, alu_wr, alu_sel, alu_op, alu_wr_addr, alu_rd_addr_a, alu_rd_addr_b,
                     instr_ready, op, rd, ra, rb);
        end
        @(negedge clk);
        vectors++;
        if (alu_wr !== 1'b0 || alu_op !== 3'd0 || alu_sel !== 1'b0 || instr_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL %s cflag: wr=%b op=%0d sel=%b ready=%b busy=%b required 0/0/0/0/1",
                     name, alu_wr, alu_op, alu_sel, instr_ready, busy);
        end
        @(negedge clk);
        vectors++;
        if (carry !== exp_carry || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL %s carry: carry=%b ready=%b required %b/1", name, carry, instr_ready, exp_carry);
        end
    endtask

    // ---------------- test scenarios ----------------
    task automatic test_reset();
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h4300;
        res_ready   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            vectors++;
            if (instr_ready !== 1'b0 || carry !== 1'b0 || res_valid !== 1'b0 ||
                alu_wr !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0000) begin
                miscompares++;
                $display("FAIL reset_hold: ready=%b carry=%b res_valid=%b wr=%b busy=%b res_data=%h required all 0",
                         instr_ready, carry, res_valid, alu_wr, busy, res_data);
            end
        end
        reset = 1'b0;
        instr = 16'h0000;
        @(negedge clk);
        instr_valid = 1'b0;
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b busy=%b required 1/0", instr_ready, busy);
        end
    endtask

    task automatic test_nop();
        send_word(16'h0000, "nop");
        vectors++;
        if (instr_ready !== 1'b1 || busy !== 1'b0 || alu_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL nop: ready=%b busy=%b wr=%b required 1/0/0", instr_ready, busy, alu_wr);
        end
    endtask

    task automatic test_ldi_rd();
        do_ldi(3'd3, 16'hBEEF, "ldi_r3");
        do_read(3'd3, 16'hBEEF, "rd_r3");
    endtask

    task automatic test_alu();
        do_ldi(3'd3, 16'hFFFF, "ldi_r3_ffff");
        do_ldi(3'd4, 16'h0002, "ldi_r4_0002");
        // 16'b10_101_010_011_100_00: r2 = r3 + r4 = 0x0001, carry out 1
        do_alu(3'd5, 3'd2, 3'd3, 3'd4, 1'b1, "alu_add_carry");
        do_read(3'd2, 16'h0001, "rd_r2_b2b");
        // r2 = r4 + r4 = 0x0004, carry out 0
        do_alu(3'd5, 3'd2, 3'd4, 3'd4, 1'b0, "alu_add_nocarry");
        do_read(3'd2, 16'h0004, "rd_r2_second");
        // r3 & r4 = 0x0002 into r5; logic op clears carry in the model
        do_alu(3'd2, 3'd5, 3'd3, 3'd4, 1'b0, "alu_and");
        do_read(3'd5, 16'h0002, "rd_r5_and");
        // ALU into r0 still updates carry: 0xFFFF + 0xFFFF carries
        do_alu(3'd0, 3'd0, 3'd3, 3'd3, 1'b1, "alu_rd0");
        do_read(3'd0, 16'h0000, "rd_r0_after_alu");
        // LDI, RD and NOP leave carry unchanged
        do_ldi(3'd6, 16'h0000, "ldi_keeps_carry");
        test_nop();
        vectors++;
        if (carry !== 1'b1) begin
            miscompares++;
            $display("FAIL carry_sticky: carry=%b required 1", carry);
        end
    endtask

    task automatic test_backpressure();
        send_word({2'b11, 3'b000, 3'b000, 3'd3, 5'b00000}, "bp_rd");
        // present a word that must be ignored while the result is pending
        instr_valid = 1'b1;
        instr       = 16'h4100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (res_valid !== 1'b1 || res_data !== 16'hFFFF || instr_ready !== 1'b0 || alu_wr !== 1'b0) begin
                miscompares++;
                $display("FAIL backpressure[%0d]: res_valid=%b res_data=%h ready=%b wr=%b required 1/ffff/0/0",
                         i, res_valid, res_data, instr_ready, alu_wr);
            end
        end
        instr_valid = 1'b0;
        instr       = 16'h0000;
        res_ready   = 1'b1;
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || instr_ready !== 1'b1 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL backpressure_release: res_valid=%b ready=%b busy=%b required 0/1/0",
                     res_valid, instr_ready, busy);
        end
    endtask

    task automatic test_r0();
        do_ldi(3'd0, 16'h1234, "ldi_r0");
        do_read(3'd0, 16'h0000, "rd_r0");
    endtask

    task automatic test_reset_mid();
        int wr_seen;
        // Reset between the LDI header and its immediate
        send_word({2'b01, 3'b000, 3'd5, 8'h00}, "rst_imm_hdr");
        reset       = 1'b1;
        instr_valid = 1'b1;
        instr       = 16'h5555;
        #1;
        vectors++;
        if (instr_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_imm_ready: instr_ready=%b required 0", instr_ready);
        end
        @(negedge clk);
        reset       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        wr_seen     = 0;
        for (int i = 0; i < 4; i++) begin
            if (alu_wr !== 1'b0) wr_seen++;
            @(negedge clk);
        end
        vectors++;
        if (wr_seen != 0 || busy !== 1'b0 || instr_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL rst_imm: wr_cycles=%0d busy=%b ready=%b required 0/0/1", wr_seen, busy, instr_ready);
        end

        // Reset while a result is pending in RESP
        do_ldi(3'd1, 16'hA5A5, "rst_resp_ldi");
        send_word({2'b11, 3'b000, 3'b000, 3'd1, 5'b00000}, "rst_resp_rd");
        @(negedge clk);
        vectors++;
        if (res_valid !== 1'b1 || res_data !== 16'hA5A5) begin
            miscompares++;
            $display("FAIL rst_resp_pre: res_valid=%b res_data=%h required 1/a5a5", res_valid, res_data);
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || busy !== 1'b0 || res_data !== 16'h0000 || carry !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resp: res_valid=%b busy=%b res_data=%h carry=%b required 0/0/0000/0",
                     res_valid, busy, res_data, carry);
        end
        res_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        vectors++;
        if (res_valid !== 1'b0 || instr_ready !== 1'b1 || alu_wr !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_resp_after: res_valid=%b ready=%b wr=%b required 0/1/0",
                     res_valid, instr_ready, alu_wr);
        end
    endtask

    initial begin
        reset       = 1'b1;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        res_ready   = 1'b0;
        test_reset();
        test_nop();
        test_ldi_rd();
        test_alu();
        test_backpressure();
        test_r0();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
